// File: rtl/sysid_regfile_ext.sv
// ---------------------------------------------------------------------------
// sysid_regfile_ext
//   Avalon-MM read/write slave that software reads at boot to identify the
//   image. It holds system ID, build timestamp and version words, a scratch
//   register, an optional 64-bit uptime counter with atomic two-word readout,
//   and a capabilities word. Reads are pipelined with a fixed latency.
//
//   Optional feature macro: SYSID_UPTIME_EN
//     defined   -> prescaler, 64-bit uptime counter and high-word snapshot
//                  are built, CAPS[0]=1
//     undefined -> words 4/5 read 0, writes to word 4 are ignored, CAPS[0]=0
//
// Ports
//   clock          in   1   system clock
//   reset_n        in   1   asynchronous active-low reset
//   address        in   3   word address
//   read           in   1   read request, one beat per cycle
//   write          in   1   write request
//   writedata      in   32  write data
//   readdata       out  32  read data, valid when readdatavalid=1
//   readdatavalid  out  1   read response strobe
//
// Word map: 0 ID, 1 TIMESTAMP, 2 VERSION, 3 SCRATCH (RW),
//           4 UPTIME_LO (write clears), 5 UPTIME_HI snapshot, 6 CAPS, 7 zero
// ---------------------------------------------------------------------------
module sysid_regfile_ext #(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'd1769038348,
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter int          READ_LATENCY  = 1,   // legal 1..4
    parameter int          PRESCALE      = 1    // legal 1..65535
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_VERSION   = 3'd2;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
    localparam logic [2:0] ADDR_CAPS      = 3'd6;

    localparam logic       PRESCALE_ONE = (PRESCALE == 1);
    localparam logic [3:0] LATENCY_NIB  = 4'(READ_LATENCY);

    logic [31:0] scratch;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi_snap;
    logic [31:0] rd_word;

    // -----------------------------------------------------------------------
    // Scratch register
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= SCRATCH_RESET;
        end else if (write && (address == ADDR_SCRATCH)) begin
            scratch <= writedata;
        end
    end

    // -----------------------------------------------------------------------
    // Uptime counter with high-word snapshot
    // -----------------------------------------------------------------------
`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;

    logic [15:0] prescale_cnt;
    logic [63:0] uptime;
    logic [31:0] snapshot;
    logic        uptime_clear;
    logic        uptime_tick;

    assign uptime_clear = write && (address == ADDR_UPTIME_LO);
    assign uptime_tick  = (prescale_cnt == 16'(PRESCALE - 1));

    // Clear has priority over a same-cycle tick; the counter wraps silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescale_cnt <= '0;
            uptime       <= '0;
        end else if (uptime_clear) begin
            prescale_cnt <= '0;
            uptime       <= '0;
        end else if (uptime_tick) begin
            prescale_cnt <= '0;
            uptime       <= uptime + 64'd1;
        end else begin
            prescale_cnt <= prescale_cnt + 16'd1;
        end
    end

    // Reading the low word freezes the high word of the same instant, so a
    // following read of word 5 is coherent with it. Clear leaves it alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snapshot <= '0;
        end else if (read && (address == ADDR_UPTIME_LO)) begin
            snapshot <= uptime[63:32];
        end
    end

    assign uptime_lo      = uptime[31:0];
    assign uptime_hi_snap = snapshot;
`else
    localparam logic UPTIME_PRESENT = 1'b0;

    assign uptime_lo      = '0;
    assign uptime_hi_snap = '0;
`endif

    localparam logic [31:0] CAPS = {16'h0000, PRESCALE_ONE, 3'b000, LATENCY_NIB,
                                    7'b000_0000, UPTIME_PRESENT};

    // -----------------------------------------------------------------------
    // Read mux: data is sampled in the cycle the read is presented, so a
    // same-cycle write is not yet visible.
    // -----------------------------------------------------------------------
    // NOTE: the output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_ID:        rd_word = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_word = TIMESTAMP;
            ADDR_VERSION:   rd_word = VERSION;
            ADDR_SCRATCH:   rd_word = scratch;
            ADDR_UPTIME_LO: rd_word = uptime_lo;
            ADDR_UPTIME_HI: rd_word = uptime_hi_snap;
            ADDR_CAPS:      rd_word = CAPS;
            default:        rd_word = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Fixed-latency read pipeline. A data stage only loads when the beat
    // entering it is valid, so the last stage holds the most recent response
    // while readdatavalid is low.
    // -----------------------------------------------------------------------
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [31:0]             pipe_data [READ_LATENCY];

    // NOTE: the data stages are reset on purpose: readdata must read 0 out of
    // reset and in-flight beats must vanish when reset hits mid-read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= read;
            if (read) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign readdatavalid = pipe_valid[READ_LATENCY-1];
    assign readdata      = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regfile_ext.sv
// ---------------------------------------------------------------------------
// tb_sysid_regfile_ext
//   Directed bench for sysid_regfile_ext. Two instances share the bus:
//     dut_a  READ_LATENCY=2, PRESCALE=1
//     dut_b  READ_LATENCY=3, PRESCALE=4
//   Expected values are hand-computed constants. Uptime-specific cases are
//   selected with SYSID_UPTIME_EN, matching the build of the design.
// ---------------------------------------------------------------------------
module tb_sysid_regfile_ext;

    localparam logic [31:0] SYS_A  = 32'hC0DE_0001;
    localparam logic [31:0] SYS_B  = 32'h0000_0B0B;
    localparam logic [31:0] TS     = 32'd1769038348;
    localparam logic [31:0] VER_A  = 32'h0001_0000;
    localparam logic [31:0] VER_B  = 32'h0002_0003;
    localparam logic [31:0] SCR_A  = 32'h1234_5678;
    localparam logic [31:0] SCR_B  = 32'h0BAD_F00D;
`ifdef SYSID_UPTIME_EN
    localparam logic [31:0] CAPS_A = 32'h0000_8201;
    localparam logic [31:0] CAPS_B = 32'h0000_0301;
`else
    localparam logic [31:0] CAPS_A = 32'h0000_8200;
    localparam logic [31:0] CAPS_B = 32'h0000_0300;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sysid_regfile_ext #(
        .SYSTEM_ID(SYS_A), .TIMESTAMP(TS), .VERSION(VER_A),
        .SCRATCH_RESET(SCR_A), .READ_LATENCY(2), .PRESCALE(1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata),
        .readdata(a_data), .readdatavalid(a_valid)
    );

    sysid_regfile_ext #(
        .SYSTEM_ID(SYS_B), .TIMESTAMP(TS), .VERSION(VER_B),
        .SCRATCH_RESET(SCR_B), .READ_LATENCY(3), .PRESCALE(4)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata),
        .readdata(b_data), .readdatavalid(b_valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one bus cycle, then return the bus to idle.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] a,
                         input logic [31:0] d);
        read      = rd;
        write     = wr;
        address   = a;
        writedata = d;
        tick();
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Read on dut_a (latency 2), optionally with a same-cycle write.
    task automatic rd_a(input string tag, input logic [2:0] a, input logic wr,
                        input logic [31:0] wd, input logic [31:0] exp);
        issue(1'b1, wr, a, wd);
        check({tag, "_early"}, {31'b0, a_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'b0, a_valid}, 32'd1);
        check({tag, "_data"}, a_data, exp);
    endtask

    // Read on dut_b (latency 3).
    task automatic rd_b(input string tag, input logic [2:0] a,
                        input logic [31:0] exp);
        issue(1'b1, 1'b0, a, 32'h0);
        tick();
        check({tag, "_early"}, {31'b0, b_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'b0, b_valid}, 32'd1);
        check({tag, "_data"}, b_data, exp);
    endtask

    logic [31:0] t3_exp [8];

    initial begin
        reset_n   = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = 3'd0;
        writedata = 32'h0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_a_valid", {31'b0, a_valid}, 32'd0);
        check("rst_a_data", a_data, 32'd0);
        check("rst_b_valid", {31'b0, b_valid}, 32'd0);
        check("rst_b_data", b_data, 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_valid", {31'b0, a_valid}, 32'd0);

        // ---- T1: constant words ----
        rd_a("t1_id", 3'd0, 1'b0, 32'h0, SYS_A);
        rd_a("t1_ts", 3'd1, 1'b0, 32'h0, TS);
        rd_a("t1_ver", 3'd2, 1'b0, 32'h0, VER_A);
        rd_a("t1_caps", 3'd6, 1'b0, 32'h0, CAPS_A);
        rd_b("t1_caps_b", 3'd6, CAPS_B);
        rd_b("t1_ver_b", 3'd2, VER_B);
        rd_a("t1_scr_rst", 3'd3, 1'b0, 32'h0, SCR_A);

        // ---- T2: scratch write/read, read-before-write, hold ----
        issue(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF);
        rd_a("t2_scr", 3'd3, 1'b0, 32'h0, 32'hDEAD_BEEF);
        rd_a("t2_rw_same", 3'd3, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF);
        tick();
        check("t2_hold_valid", {31'b0, a_valid}, 32'd0);
        check("t2_hold_data", a_data, 32'hDEAD_BEEF);
        rd_a("t2_scr_new", 3'd3, 1'b0, 32'h0, 32'h0000_0001);
        issue(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF);
        issue(1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF);
        issue(1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF);
        rd_a("t2_ro_id", 3'd0, 1'b0, 32'h0, SYS_A);
        rd_a("t2_ro_caps", 3'd6, 1'b0, 32'h0, CAPS_A);
        rd_a("t2_unmapped", 3'd7, 1'b0, 32'h0, 32'h0);

        // ---- T3: back-to-back reads 0..7 after an uptime clear ----
        // Counter is 0 in the first read cycle and +1 per clock, so the
        // read of word 4 (fifth cycle) sees 4; the high word is still 0.
        t3_exp[0] = SYS_A;
        t3_exp[1] = TS;
        t3_exp[2] = VER_A;
        t3_exp[3] = 32'h0000_0001;
`ifdef SYSID_UPTIME_EN
        t3_exp[4] = 32'd4;
`else
        t3_exp[4] = 32'd0;
`endif
        t3_exp[5] = 32'd0;
        t3_exp[6] = CAPS_A;
        t3_exp[7] = 32'd0;
        issue(1'b0, 1'b1, 3'd4, 32'h0);
        for (int i = 0; i < 9; i++) begin
            read    = (i < 8);
            address = 3'(i);
            tick();
            if (i == 0) begin
                check("t3_first_gap", {31'b0, a_valid}, 32'd0);
            end else begin
                check($sformatf("t3_valid%0d", i - 1), {31'b0, a_valid}, 32'd1);
                check($sformatf("t3_data%0d", i - 1), a_data, t3_exp[i-1]);
            end
        end
        read = 1'b0;
        tick();
        check("t3_end_valid", {31'b0, a_valid}, 32'd0);

`ifdef SYSID_UPTIME_EN
        // ---- T4: atomic readout across a low-word wrap ----
        force dut_a.uptime = 64'h0000_0000_FFFF_FFFF;
        rd_a("t4_lo", 3'd4, 1'b0, 32'h0, 32'hFFFF_FFFF);
        force dut_a.uptime = 64'h0000_0001_0000_0000;
        rd_a("t4_hi_snap", 3'd5, 1'b0, 32'h0, 32'h0);
        rd_a("t4_lo2", 3'd4, 1'b0, 32'h0, 32'h0);
        rd_a("t4_hi_snap2", 3'd5, 1'b0, 32'h0, 32'h1);
        release dut_a.uptime;
        issue(1'b0, 1'b1, 3'd4, 32'h0);

        // ---- T5: PRESCALE=4 count, clear, snapshot survives clear ----
        // 40 clocks after the clear the counter reads 40/4 = 10.
        issue(1'b0, 1'b1, 3'd4, 32'h0);
        repeat (40) tick();
        rd_b("t5_count", 3'd4, 32'd10);
        force dut_b.uptime = 64'h0000_00AB_0000_0010;
        rd_b("t5_lo_forced", 3'd4, 32'h0000_0010);
        release dut_b.uptime;
        issue(1'b0, 1'b1, 3'd4, 32'h0);
        rd_b("t5_snap_kept", 3'd5, 32'h0000_00AB);
        rd_b("t5_after_clear", 3'd4, 32'd0);
`else
        // ---- uptime absent: words 4/5 read 0, write to 4 ignored ----
        issue(1'b0, 1'b1, 3'd4, 32'h5555_AAAA);
        rd_a("nu_lo", 3'd4, 1'b0, 32'h0, 32'h0);
        rd_a("nu_hi", 3'd5, 1'b0, 32'h0, 32'h0);
        rd_b("nu_lo_b", 3'd4, 32'h0);
`endif

        // ---- T6: reset one cycle after a read on dut_b (latency 3) ----
        issue(1'b1, 1'b0, 3'd3, 32'h0);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, b_valid}, 32'd0);
        check("t6_rst_data", b_data, 32'd0);
        tick();
        check("t6_rst_valid2", {31'b0, b_valid}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_no_beat%0d", i), {31'b0, b_valid | a_valid}, 32'd0);
        end
        rd_b("t6_scr_b", 3'd3, SCR_B);
        rd_a("t6_scr_a", 3'd3, 1'b0, 32'h0, SCR_A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
